// File: rtl/rr_frontend_pkg.sv
// Shared constants, output FSM state type and grant-decoding helpers for the
// round-robin request frontend.
package rr_frontend_pkg;

  localparam int NUM_PORTS  = 4;
  localparam int DATA_W_DEF = 8;
  localparam int PORT_W     = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } out_state_t;

  function automatic logic gnt_is_onehot(input logic [NUM_PORTS-1:0] g);
    return ($countones(g) == 1);
  endfunction

  // Only meaningful when g is one-hot; returns 0 for an all-zero vector.
  function automatic logic [PORT_W-1:0] gnt_index(input logic [NUM_PORTS-1:0] g);
    logic [PORT_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (g[i]) idx = PORT_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/port_slot.sv
// Single-entry holding register for one upstream port. Accepts a beat only
// while empty; the pop request clears it and the refill waits a cycle.
module port_slot
  import rr_frontend_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              pop,
  output logic              full,
  output logic [DATA_W-1:0] data
);

  assign in_ready = ~full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      data <= '0;
    end else begin
      if (pop) begin
        full <= 1'b0;
      end
      // in_ready is ~full, so a capture never coincides with a pop of this slot.
      if (in_valid && !full) begin
        full <= 1'b1;
        data <= in_data;
      end
    end
  end

endmodule

// File: rtl/rr_req_frontend.sv
// Four single-entry port slots feeding an external round-robin arbiter; the
// granted slot is moved into a registered valid/ready output stage.
module rr_req_frontend
  import rr_frontend_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          in_valid,
  output logic [NUM_PORTS-1:0]          in_ready,
  input  logic [NUM_PORTS*DATA_W-1:0]   in_data,
  output logic [NUM_PORTS-1:0]          req,
  input  logic [NUM_PORTS-1:0]          gnt,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic [PORT_W-1:0]             out_port,
  output logic                          err_gnt,
  output out_state_t                    fsm_state
);

  // Handshake: a beat transfers on any edge where valid && ready; valid never
  // depends on ready, and a held beat stays stable until it transfers.

  logic [NUM_PORTS-1:0] full;
  logic [NUM_PORTS-1:0] pop_vec;
  logic [DATA_W-1:0]    slot_data [NUM_PORTS];

  out_state_t           state;
  logic                 gnt_ok;
  logic [PORT_W-1:0]    gnt_idx;
  logic                 can_load;
  logic                 pop_en;
  logic                 gnt_bad;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_slot
    port_slot #(.DATA_W(DATA_W)) u_slot (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid[i]),
      .in_ready (in_ready[i]),
      .in_data  (in_data[i*DATA_W +: DATA_W]),
      .pop      (pop_vec[i]),
      .full     (full[i]),
      .data     (slot_data[i])
    );
  end

  assign req       = full;
  assign fsm_state = state;

  assign gnt_ok   = gnt_is_onehot(gnt);
  assign gnt_idx  = gnt_index(gnt);
  assign can_load = (state == ST_IDLE) || out_ready;
  // A one-hot grant at an empty slot is legal (arbiter idle default) and pops nothing.
  assign pop_en   = gnt_ok && ((gnt & full) != '0) && can_load;
  assign pop_vec  = pop_en ? gnt : '0;
  assign gnt_bad  = (full != '0) && !gnt_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_port  <= '0;
      err_gnt   <= 1'b0;
    end else begin
      err_gnt <= gnt_bad;
      case (state)
        ST_IDLE: begin
          if (pop_en) begin
            state     <= ST_HOLD;
            out_valid <= 1'b1;
            out_data  <= slot_data[gnt_idx];
            out_port  <= gnt_idx;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            if (pop_en) begin
              out_data <= slot_data[gnt_idx];
              out_port <= gnt_idx;
            end else begin
              state     <= ST_IDLE;
              out_valid <= 1'b0;
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/rr_req_frontend.md
RR_REQ_FRONTEND -- requirements
Module: rr_req_frontend

Interface
REQ-001 Parameter DATA_W, default 8, payload width per port.
REQ-002 The block SHALL use reset rst, asynchronous, active-high, and clock clk.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 in_valid  input  4  per-port upstream valid.
REQ-006 in_ready  output  4  per-port upstream ready.
REQ-007 in_data  input  4*DATA_W  payloads; port i occupies bits [i*DATA_W +: DATA_W].
REQ-008 req  output  4  request vector to the round-robin arbiter; bit i means port i holds data.
REQ-009 gnt  input  4  one-hot grant from the arbiter.
REQ-010 out_valid  output  1  downstream valid.
REQ-011 out_ready  input  1  downstream ready.
REQ-012 out_data  output  DATA_W  selected payload.
REQ-013 out_port  output  2  index of the port that supplied out_data.
REQ-014 err_gnt  output  1  one-cycle registered pulse flagging an illegal grant.

Function
REQ-015 Each port SHALL hold one single-entry slot: a full flag plus a DATA_W data register.
REQ-016 in_ready[i] SHALL equal the inverse of full[i]: no combinational bypass, no same-cycle refill of a slot being popped.
REQ-017 On in_valid[i] && in_ready[i] at a clock edge, slot i SHALL capture in_data[i] and set full[i].
REQ-018 req SHALL equal the full vector combinationally, so the arbiter sees occupancy in the same cycle.
REQ-019 Output FSM states: IDLE (out_valid=0) and HOLD (out_valid=1).
REQ-020 Eligible pop: gnt is exactly one-hot, full[k] is set for the granted index k, and the output register can load.
REQ-021 The output register can load in IDLE, or in HOLD when out_ready=1 in the same cycle.
REQ-022 On an eligible pop, the block SHALL load out_data from slot k, set out_port to k, clear full[k] and be in HOLD next cycle.
REQ-023 In IDLE with no eligible pop, the FSM SHALL stay in IDLE.
REQ-024 In HOLD with out_ready=0, out_valid, out_data and out_port SHALL stay stable and no slot SHALL be popped.
REQ-025 In HOLD with out_ready=1:
- with an eligible pop, the FSM SHALL reload back-to-back and stay in HOLD;
- without one, the FSM SHALL go to IDLE.
REQ-026 Latency: data accepted at edge N SHALL appear on out_valid no earlier than edge N+1 (slot, then output register).
REQ-027 Sustained throughput SHALL be one beat per cycle while several ports stay full and out_ready=1.
REQ-028 A grant pointing at an empty slot SHALL cause no pop and no error; this case is legal at idle, where the arbiter resets to gnt=0001.
REQ-029 If req is non-zero and gnt is not one-hot (zero or multi-hot), the block SHALL suppress the pop and pulse err_gnt for one cycle on the next edge.
REQ-030 A slot capture and an output pop on different ports in the same cycle SHALL both take effect.

Reset
REQ-031 On rst assertion, asynchronously:
- full all zero;
- slot data, out_data and out_port zero;
- out_valid 0, err_gnt 0;
- FSM in IDLE.
REQ-032 A reset asserted mid-transfer SHALL discard every held beat; after release, in_ready=4'b1111 and req=0.

Structure
REQ-033 Shared package rr_frontend_pkg SHALL hold NUM_PORTS=4, the DATA_W default and the output FSM state enum.
REQ-034 Sub-module port_slot (single-entry holding register with valid/ready in, full/pop out) SHALL be instantiated four times.
REQ-035 RTL scope: 120-400 lines total.

Verification
REQ-036 Reset release, no traffic, gnt=0001 -> in_ready=1111, req=0000, out_valid=0, err_gnt=0 indefinitely.
REQ-037 Port 2 sends 0xA5, gnt=0100, out_ready=1 -> req=0100 one cycle after capture; next edge out_valid=1, out_data=0xA5, out_port=2, req=0000.
REQ-038 All four ports full (0x10,0x11,0x12,0x13), arbiter model rotating 1->2->3->0, out_ready=1 -> four consecutive beats on out_port 1,2,3,0 with no idle cycle.
REQ-039 Port 0 holding 0x55, out_ready=0 for 5 cycles -> out_valid, out_data and out_port stable; in_ready[0] returns 1 after the pop; only one beat is delivered once out_ready=1.
REQ-040 req=0010 with gnt forced to 0110 -> no pop, err_gnt=1 for exactly one cycle, full[1] still set.
REQ-041 rst pulsed while in HOLD with ports 1 and 3 full -> all outputs return to reset values immediately; no stale beat after release.
